// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: transmitter states,
// common command bytes and the device ACK response.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        WAIT_DEV,
        DATA,
        PARITY,
        STOP,
        ACK_WAIT
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the PS/2 clock and data pins and detects clock falling edges.
// Define PS2_TX_GLITCH_FILTER_EN to add a 4-sample stability filter on the clock.
module ps2_line_sync (
    input  logic clk,
    input  logic resetn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk};
            data_ff <= {data_ff[0], ps2_data};
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [3:0] clk_hist;
    logic       clk_filt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_hist <= 4'hF;
            clk_filt <= 1'b1;
        end else begin
            clk_hist <= {clk_hist[2:0], clk_ff[1]};
            if (clk_hist == 4'hF)
                clk_filt <= 1'b1;
            else if (clk_hist == 4'h0)
                clk_filt <= 1'b0;
        end
    end

    assign clk_sync = clk_filt;
`else
    assign clk_sync = clk_ff[1];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            clk_prev <= 1'b1;
        else
            clk_prev <= clk_sync;
    end

    assign fall      = clk_prev & ~clk_sync;
    assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame, ACK check.
// Clock filtering in ps2_line_sync is enabled by PS2_TX_GLITCH_FILTER_EN.
//
// state    | meaning
// IDLE     | ready for a command byte
// INHIBIT  | clock held low; start bit driven in the last cycle
// WAIT_DEV | clock released, waiting for the first device clock fall
// DATA     | shifting out data bits on device clock falls
// PARITY   | parity bit on the line
// STOP     | data released for the stop bit; next fall samples ACK
// ACK_WAIT | waiting for both lines to return high
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam int MAX_CYC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state;
    logic [7:0]    byte_q;
    logic          parity_q;
    logic [3:0]    idx;
    logic [CW-1:0] timer;
    logic          clk_drive;
    logic          data_drive;
    logic          clk_sync;
    logic          data_sync;
    logic          fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .fall      (fall)
    );

    // One down-counter serves both the inhibit period and the edge timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            idx         <= '0;
            timer       <= '0;
            clk_drive   <= 1'b0;
            data_drive  <= 1'b0;
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        byte_q      <= tx_data;
                        parity_q    <= odd_parity(tx_data);
                        idx         <= '0;
                        timer       <= INH_LOAD;
                        err_nack    <= 1'b0;
                        err_timeout <= 1'b0;
                        clk_drive   <= 1'b1;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == CW'(1))
                        data_drive <= 1'b1;
                    if (timer == '0) begin
                        clk_drive  <= 1'b0;
                        data_drive <= 1'b1;
                        timer      <= TO_LOAD;
                        state      <= WAIT_DEV;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    if (state == ACK_WAIT && clk_sync && data_sync) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (fall) begin
                        timer <= TO_LOAD;
                        case (state)
                            WAIT_DEV: begin
                                data_drive <= ~byte_q[0];
                                idx        <= 4'd1;
                                state      <= DATA;
                            end
                            DATA: begin
                                if (idx == 4'd8) begin
                                    data_drive <= ~parity_q;
                                    state      <= PARITY;
                                end else begin
                                    data_drive <= ~byte_q[idx[2:0]];
                                    idx        <= idx + 4'd1;
                                end
                            end
                            PARITY: begin
                                data_drive <= 1'b0;
                                state      <= STOP;
                            end
                            STOP: begin
                                err_nack <= data_sync;
                                state    <= ACK_WAIT;
                            end
                            default: ;
                        endcase
                    end else if (timer == '0) begin
                        clk_drive   <= 1'b0;
                        data_drive  <= 1'b0;
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
            endcase
        end
    end

    assign ps2_clk_drive_low  = clk_drive;
    assign ps2_data_drive_low = data_drive;
    assign busy               = (state != IDLE);
    assign tx_ready           = (state == IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model, frame-level reference
// model and a per-cycle compare process.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;
    logic       clk_dl;
    logic       data_dl;
    logic       busy;
    logic       done;
    logic       err_nack;
    logic       err_timeout;

    logic dev_clk_low;
    logic dev_data_low;

    assign ps2_clk_pin  = ~(clk_dl | dev_clk_low);
    assign ps2_data_pin = ~(data_dl | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(200)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .ps2_clk            (ps2_clk_pin),
        .ps2_data           (ps2_data_pin),
        .ps2_clk_drive_low  (clk_dl),
        .ps2_data_drive_low (data_dl),
        .busy               (busy),
        .done               (done),
        .err_nack           (err_nack),
        .err_timeout        (err_timeout)
    );

    int vectors    = 0;
    int miscompares = 0;

    // model / monitor state
    int  cyc = 0;
    int  done_cnt = 0;
    int  rel_cyc = 0;
    int  done_gap = 0;
    int  inh_len = 0;
    int  inh_ovl = 0;
    int  last_inh = 0;
    int  last_ovl = 0;
    bit  prev_cdl = 0;
    bit  pend_nack = 0;
    bit  pend_to = 0;
    bit  held_nack = 0;
    bit  held_to = 0;
    int  dev_falls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Frame as the device sees it on rising edges 1..10: data LSB first, odd parity, stop.
    function automatic bit [9:0] frame_bits(input bit [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    task automatic device(input int nfalls, input bit ack, input int dly,
                          output bit start_bit, output bit [9:0] samp, output bit req_seen);
        int t = 0;
        samp = '0;
        start_bit = 1'b1;
        while (!(data_dl && !clk_dl) && t < 100) begin
            tick();
            t++;
        end
        req_seen = (t < 100);
        if (!req_seen) return;
        start_bit = ps2_data_pin;
        repeat (dly) tick();
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (20) tick();
            dev_clk_low = 1'b0;
            if (k <= 10) samp[k-1] = ps2_data_pin;
            if (k == 11) dev_data_low = 1'b0;
            repeat (5) tick();
            if (k == 10) dev_data_low = ack;
            repeat (15) tick();
        end
    endtask

    task automatic send(input bit [7:0] b);
        tick();
        check("ready_before_send", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int limit);
        int t = 0;
        while (done_cnt == start && t < limit) begin
            tick();
            t++;
        end
        check("done_seen", done_cnt - start, 1);
    endtask

    task automatic run_frame(input bit [7:0] b, input bit ack, input int dly,
                             input bit inject, output bit [9:0] samp);
        bit sb, rq;
        int start;
        pend_nack = !ack;
        pend_to   = 1'b0;
        start     = done_cnt;
        fork
            device(11, ack, dly, sb, samp, rq);
            begin
                send(b);
                if (inject) begin
                    repeat (150) tick();
                    tx_valid = 1'b1;
                    tx_data  = 8'h55;
                    repeat (4) tick();
                    tx_valid = 1'b0;
                end
            end
        join
        wait_done(start, 300);
        check("request_seen", rq, 1);
        check("start_bit", sb, 0);
        check("frame_bits", samp, frame_bits(b));
        check("inhibit_len", last_inh, 10);
        check("start_overlap", last_ovl, 1);
        repeat (100) tick();
        check("single_done", done_cnt - start, 1);
        check("ready_after", tx_ready, 1);
    endtask

    initial begin
        bit [9:0] samp;
        resetn       = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!resetn) begin
                        held_nack = 0;
                        held_to   = 0;
                        inh_len   = 0;
                        inh_ovl   = 0;
                        prev_cdl  = 0;
                    end else begin
                        check("ready_vs_busy", tx_ready, !busy);
                        if (done) begin
                            done_cnt++;
                            check("nack_at_done", err_nack, pend_nack);
                            check("timeout_at_done", err_timeout, pend_to);
                            check("released_at_done", {clk_dl, data_dl}, 0);
                            held_nack = pend_nack;
                            held_to   = pend_to;
                            done_gap  = cyc - rel_cyc;
                        end else if (!busy) begin
                            check("idle_flags", {err_nack, err_timeout}, {held_nack, held_to});
                            check("idle_released", {clk_dl, data_dl}, 0);
                        end
                        if (clk_dl) begin
                            inh_len++;
                            if (data_dl) inh_ovl++;
                        end
                        if (prev_cdl && !clk_dl) begin
                            last_inh = inh_len;
                            last_ovl = inh_ovl;
                            inh_len  = 0;
                            inh_ovl  = 0;
                            rel_cyc  = cyc;
                        end
                        prev_cdl = clk_dl;
                    end
                    cyc++;
                end
            end
            begin : main
                int start;
                bit sb, rq;
                repeat (3) tick();
                check("rst_outputs",
                      {tx_ready, busy, done, clk_dl, data_dl, err_nack, err_timeout},
                      7'b1000000);
                resetn = 1'b1;
                repeat (5) tick();

                run_frame(8'hED, 1'b1, 10, 1'b0, samp);
                check("pin_ed", samp, 10'h3ED);
                run_frame(8'h01, 1'b1, 10, 1'b0, samp);
                check("pin_01", samp, 10'h201);
                run_frame(8'hFF, 1'b1, 10, 1'b0, samp);
                check("pin_ff", samp, 10'h3FF);

                // device leaves data high at the 11th fall
                run_frame(8'h3C, 1'b0, 10, 1'b0, samp);
                check("nack_held", err_nack, 1);

                // tx_valid mid-frame is ignored
                run_frame(8'hA3, 1'b1, 10, 1'b1, samp);

                // no device clocking after inhibit
                pend_nack = 1'b0;
                pend_to   = 1'b1;
                start     = done_cnt;
                send(8'hF4);
                wait_done(start, 400);
                check("timeout_gap", done_gap, 200);
                check("timeout_inhibit_len", last_inh, 10);
                repeat (20) tick();
                check("timeout_held", {err_timeout, err_nack}, 2'b10);

                for (int n = 0; n < 6; n++) begin
                    run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                              $urandom_range(2, 80), 1'b0, samp);
                end

                // reset after the 4th fall
                dev_falls = 0;
                start     = done_cnt;
                fork
                    device(4, 1'b1, 10, sb, samp, rq);
                    begin
                        int t = 0;
                        send(8'hA7);
                        while (dev_falls < 4 && t < 1000) begin
                            tick();
                            t++;
                        end
                        repeat (5) tick();
                        check("pre_reset_data_low", data_dl, 1);
                        resetn = 1'b0;
                        #1;
                        check("async_reset_lines", {clk_dl, data_dl}, 0);
                        check("async_reset_state", {busy, tx_ready, done}, 3'b010);
                        repeat (3) tick();
                        resetn = 1'b1;
                    end
                join
                repeat (300) tick();
                check("no_done_after_reset", done_cnt - start, 0);
                check("ready_after_reset", {tx_ready, busy}, 2'b10);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
